// File: rtl/running_line_render_if.sv
// Pixel-side bundle for running_line_render: timing in, font ROM link, VGA out.
// Build option: RUNNING_LINE_PAUSE_EN adds the pause input.
// master = timing generator / ROM / pins side, slave = the renderer.
interface running_line_render_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic [10:0]      font_addr;
  logic [7:0]       font_data;
`ifdef RUNNING_LINE_PAUSE_EN
  logic             pause;
`endif
  logic             hsync_o;
  logic             vsync_o;
  logic             de_o;
  logic [3:0]       vga_r;
  logic [3:0]       vga_g;
  logic [3:0]       vga_b;

  modport master (
`ifdef RUNNING_LINE_PAUSE_EN
    output pause,
`endif
    output sx, sy, de, hsync, vsync, font_data,
    input  font_addr, hsync_o, vsync_o, de_o, vga_r, vga_g, vga_b
  );

  modport slave (
`ifdef RUNNING_LINE_PAUSE_EN
    input  pause,
`endif
    input  sx, sy, de, hsync, vsync, font_data,
    output font_addr, hsync_o, vsync_o, de_o, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/running_line_render.sv
// running_line_render: draws a right-to-left scrolling text band into 12-bit RGB.
// Fixed 3-cycle latency from sx/sy/de/syncs to colour, de_o and syncs.
// Build option: RUNNING_LINE_PAUSE_EN (pause input freezes the scroll on frame ticks).
module running_line_render #(
  parameter int          CORDW      = 10,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          LINE_Y     = 224,
  parameter int          SCALE_LOG2 = 2,
  parameter int          MSG_LEN    = 16,
  parameter logic [8*MSG_LEN-1:0] MSG = "RUNNING LINE VGA",
  parameter int          SPEED      = 2,
  parameter logic [11:0] FG_RGB     = 12'hFF0,
  parameter logic [11:0] BG_RGB     = 12'h008
) (
  input logic              clk_pix,
  input logic              rst,
  running_line_render_if.slave io
);
  localparam int GH  = 8 << SCALE_LOG2;
  localparam int L   = H_RES + MSG_LEN * GH;
  // wide enough for any sx plus any scroll before the wrap subtract
  localparam int SW  = $clog2((1 << CORDW) + L);
  localparam int CIW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [MSG_LEN-1:0][7:0] MSG_ARR = MSG;

  logic [SW-1:0]  r_scroll;
  logic [10:0]    r_font_addr;
  logic           r_text1, r_band1, r_text2, r_band2;
  logic [2:0]     r_col1, r_col2;
  logic [2:0]     r_de_pipe, r_hs_pipe, r_vs_pipe;
  logic [11:0]    r_rgb;

  logic           w_run, w_tick;
  logic [SW-1:0]  w_scroll_sum, w_scroll_nx;
  logic [SW-1:0]  w_vx_sum, w_vx, w_tx;
  logic           w_in_band, w_in_text;
  logic [CIW-1:0] w_ci, w_char_idx;
  logic [2:0]     w_col, w_row;
  logic [7:0]     w_char;
  logic           w_bit;

`ifdef RUNNING_LINE_PAUSE_EN
  assign w_run = ~io.pause;
`else
  assign w_run = 1'b1;
`endif

  // frame tick on the last active pixel, so scroll is stable across a visible frame
  assign w_tick       = io.de && (io.sx == CORDW'(H_RES - 1)) && (io.sy == CORDW'(V_RES - 1)) && w_run;
  assign w_scroll_sum = r_scroll + SW'(SPEED);
  assign w_scroll_nx  = (w_scroll_sum >= SW'(L)) ? w_scroll_sum - SW'(L) : w_scroll_sum;

  // stage 0: position within the virtual strip [blank H_RES | message]
  assign w_vx_sum   = SW'(io.sx) + r_scroll;
  assign w_vx       = (w_vx_sum >= SW'(L)) ? w_vx_sum - SW'(L) : w_vx_sum;
  assign w_in_band  = io.de && (io.sy >= CORDW'(LINE_Y)) && (io.sy < CORDW'(LINE_Y + GH));
  assign w_in_text  = w_in_band && (w_vx >= SW'(H_RES));
  assign w_tx       = w_vx - SW'(H_RES);
  assign w_ci       = CIW'(w_tx >> (SCALE_LOG2 + 3));
  assign w_col      = 3'(w_tx >> SCALE_LOG2);
  assign w_row      = 3'((io.sy - CORDW'(LINE_Y)) >> SCALE_LOG2);
  // char 0 sits in the top byte of MSG
  assign w_char_idx = CIW'(MSG_LEN - 1) - w_ci;
  assign w_char     = MSG_ARR[w_char_idx];

  // scroll position, advanced once per frame tick and wrapped at the strip length
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst)         r_scroll <= '0;
    else if (w_tick) r_scroll <= w_scroll_nx;
  end

  // stage 1: issue the ROM address (held outside the text) and carry pixel context
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_font_addr <= '0;
      r_text1     <= 1'b0;
      r_band1     <= 1'b0;
      r_col1      <= '0;
    end else begin
      if (w_in_text) r_font_addr <= {w_char, w_row};
      r_text1 <= w_in_text;
      r_band1 <= w_in_band;
      r_col1  <= w_col;
    end
  end

  // stage 2: wait out the ROM read; font_data becomes valid for this pixel after this edge
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_text2 <= 1'b0;
      r_band2 <= 1'b0;
      r_col2  <= '0;
    end else begin
      r_text2 <= r_text1;
      r_band2 <= r_band1;
      r_col2  <= r_col1;
    end
  end

  // de and syncs ride a 3-deep shift register; syncs idle high
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_de_pipe <= '0;
      r_hs_pipe <= '1;
      r_vs_pipe <= '1;
    end else begin
      r_de_pipe <= {r_de_pipe[1:0], io.de};
      r_hs_pipe <= {r_hs_pipe[1:0], io.hsync};
      r_vs_pipe <= {r_vs_pipe[1:0], io.vsync};
    end
  end

  // stage 3: the glyph bit is taken straight from the ROM output to keep latency at 3
  assign w_bit = io.font_data[3'd7 - r_col2];

  // colour select: text pixel, band background, or black
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst)                            r_rgb <= '0;
    else if (!r_de_pipe[1])             r_rgb <= '0;
    else if (r_band2 && r_text2 && w_bit) r_rgb <= FG_RGB;
    else if (r_band2)                   r_rgb <= BG_RGB;
    else                                r_rgb <= '0;
  end

  assign io.font_addr = r_font_addr;
  assign io.de_o      = r_de_pipe[2];
  assign io.hsync_o   = r_hs_pipe[2];
  assign io.vsync_o   = r_vs_pipe[2];
  assign io.vga_r     = r_rgb[11:8];
  assign io.vga_g     = r_rgb[7:4];
  assign io.vga_b     = r_rgb[3:0];
endmodule

// File: tb/tb_running_line_render.sv
// Directed bench for running_line_render with a synchronous font ROM model.
module tb_running_line_render;
  localparam int L     = 1152;
  localparam int SPEED = 2;

  logic clk_pix;
  logic rst;
  running_line_render_if #(.CORDW(10)) rif ();

  running_line_render dut (.clk_pix(clk_pix), .rst(rst), .io(rif));

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // ROM: 'R' rows light the leftmost pixel, every other glyph the rightmost
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return (a[10:3] == 8'h52) ? 8'h80 : 8'h01;
  endfunction
  always @(posedge clk_pix) rif.font_data <= rom_fn(rif.font_addr);

  int total = 0;
  int bad   = 0;
  int exp_scroll = 0;
  int ticks = 0;
  bit paused = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_de_o"}, int'(rif.de_o), 0);
    chk({tag, "_rgb"}, int'({rif.vga_r, rif.vga_g, rif.vga_b}), 0);
    chk({tag, "_hsync_o"}, int'(rif.hsync_o), 1);
    chk({tag, "_vsync_o"}, int'(rif.vsync_o), 1);
    chk({tag, "_font_addr"}, int'(rif.font_addr), 0);
    chk({tag, "_scroll"}, int'(dut.r_scroll), 0);
  endtask

  // one active pixel at (639,479) is a frame tick
  task automatic do_tick();
    @(negedge clk_pix);
    rif.sx = 10'd639; rif.sy = 10'd479; rif.de = 1'b1;
    @(negedge clk_pix);
    rif.de = 1'b0; rif.sx = '0; rif.sy = '0;
    if (!paused) exp_scroll = (exp_scroll + SPEED) % L;
    ticks++;
    chk("scroll", int'(dut.r_scroll), exp_scroll);
    chk("scroll_range", int'(dut.r_scroll < 12'd1152), 1);
  endtask

  typedef struct {
    int         nticks;
    int         sx;
    int         sy;
    bit         de;
    bit         ca;
    int         addr;
    logic [11:0] rgb;
  } vec_t;

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk_pix);
    rif.sx = 10'(v.sx); rif.sy = 10'(v.sy); rif.de = v.de;
    @(negedge clk_pix);
    rif.de = 1'b0;
    if (v.ca) chk($sformatf("addr[%0d]", idx), int'(rif.font_addr), v.addr);
    @(negedge clk_pix);
    @(negedge clk_pix);
    chk($sformatf("rgb[%0d]", idx), int'({rif.vga_r, rif.vga_g, rif.vga_b}), int'(v.rgb));
    chk($sformatf("de_o[%0d]", idx), int'(rif.de_o), int'(v.de));
  endtask

  vec_t vecs[$];
  bit hs_arr[160];
  bit vs_arr[160];
  bit de_arr[160];

  initial begin
    // ticks, sx, sy, de, check addr, addr, rgb
    vecs.push_back('{0,   0, 224, 1, 0, 0,      12'h008});
    vecs.push_back('{0, 639, 224, 1, 0, 0,      12'h008});
    vecs.push_back('{0, 639, 255, 1, 0, 0,      12'h008});
    vecs.push_back('{0, 320, 223, 1, 0, 0,      12'h000});
    vecs.push_back('{0, 320, 256, 1, 0, 0,      12'h000});
    vecs.push_back('{0, 100, 240, 0, 0, 0,      12'h000});
    vecs.push_back('{1, 638, 224, 1, 1, 'h290,  12'hFF0});
    vecs.push_back('{1, 639, 224, 1, 1, 'h290,  12'hFF0});
    vecs.push_back('{1, 637, 224, 1, 1, 'h290,  12'h008});
    vecs.push_back('{1, 639, 231, 1, 1, 'h291,  12'hFF0});
    vecs.push_back('{1, 638, 255, 1, 1, 'h297,  12'hFF0});
    vecs.push_back('{1, 638, 256, 1, 1, 'h297,  12'h000});
    vecs.push_back('{1, 638, 223, 1, 0, 0,      12'h000});
    vecs.push_back('{1, 638, 224, 0, 0, 0,      12'h000});
    vecs.push_back('{20, 600, 224, 1, 1, 'h290, 12'hFF0});
    vecs.push_back('{20, 639, 224, 1, 1, 'h2A8, 12'h008});
    vecs.push_back('{50, 600, 224, 1, 1, 'h2A8, 12'hFF0});
    vecs.push_back('{50, 603, 240, 1, 1, 'h2AC, 12'hFF0});
    vecs.push_back('{50, 604, 224, 1, 1, 'h270, 12'h008});
    vecs.push_back('{575,   0, 224, 1, 1, 'h208, 12'hFF0});
    vecs.push_back('{575,   1, 224, 1, 1, 'h208, 12'hFF0});
    vecs.push_back('{575,   2, 224, 1, 1, 'h208, 12'h008});
    vecs.push_back('{575, 639, 224, 1, 1, 'h208, 12'h008});

    // reset held with live inputs; outputs must sit at idle values
    rst = 1'b1;
    rif.sx = 10'd630; rif.sy = 10'd224; rif.de = 1'b1;
    rif.hsync = 1'b0; rif.vsync = 1'b0;
`ifdef RUNNING_LINE_PAUSE_EN
    rif.pause = 1'b0;
`endif
    #100;
    @(negedge clk_pix);
    check_reset_outputs("rst0");
    rst = 1'b0;
    rif.de = 1'b0; rif.hsync = 1'b1; rif.vsync = 1'b1; rif.sx = '0; rif.sy = '0;
    repeat (4) @(negedge clk_pix);

    // sync / de pass-through: stream and compare against a 3-deep history
    for (int k = 0; k < 160; k++) begin
      int px;
      px = 640 + k;
      hs_arr[k] = !(px >= 656 && px < 752);
      vs_arr[k] = !(k >= 20 && k < 26);
      de_arr[k] = (k % 3 == 0);
      @(negedge clk_pix);
      if (k >= 3) begin
        chk($sformatf("hsync_o[%0d]", k), int'(rif.hsync_o), int'(hs_arr[k-3]));
        chk($sformatf("vsync_o[%0d]", k), int'(rif.vsync_o), int'(vs_arr[k-3]));
        chk($sformatf("de_o_s[%0d]", k), int'(rif.de_o), int'(de_arr[k-3]));
      end
      rif.sx = 10'(px); rif.sy = 10'd0;
      rif.hsync = hs_arr[k]; rif.vsync = vs_arr[k]; rif.de = de_arr[k];
    end
    @(negedge clk_pix);
    rif.de = 1'b0; rif.hsync = 1'b1; rif.vsync = 1'b1;
    repeat (3) @(negedge clk_pix);

    // table: advance scroll by frame ticks, then probe single pixels
    foreach (vecs[i]) begin
      while (ticks < vecs[i].nticks) do_tick();
      apply_vec(vecs[i], i);
    end

    // the 576th tick wraps the scroll back to 0
    while (ticks < 576) do_tick();
    chk("scroll_wrap0", int'(dut.r_scroll), 0);

`ifdef RUNNING_LINE_PAUSE_EN
    do_tick();
    paused = 1; rif.pause = 1'b1;
    repeat (3) do_tick();
    paused = 0; rif.pause = 1'b0;
    do_tick();
    do_tick();
`endif

    // reset in the middle of active band pixels
    repeat (3) do_tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_pix);
      rif.sx = 10'(600 + k); rif.sy = 10'd224; rif.de = 1'b1;
      rif.hsync = 1'b0; rif.vsync = 1'b0;
    end
    @(negedge clk_pix);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    #99;
    @(negedge clk_pix);
    check_reset_outputs("rst_hold");
    rst = 1'b0; exp_scroll = 0;
    rif.de = 1'b0; rif.hsync = 1'b1; rif.vsync = 1'b1;
    apply_vec('{0, 638, 224, 1, 0, 0, 12'h008}, 100);
    chk("scroll_after_rst", int'(dut.r_scroll), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
